// File: rtl/hazard_bypass_unit_if.sv
// Decode-stage instruction fields in, hazard control and bypass selects out.
interface hazard_bypass_unit_if #(
    parameter int REG_BITS = 5
);
    logic                i_id_valid;
    logic [REG_BITS-1:0] i_id_rs;
    logic [REG_BITS-1:0] i_id_rt;
    logic                i_id_uses_rs;
    logic                i_id_uses_rt;
    logic [REG_BITS-1:0] i_id_rd;
    logic                i_id_writes;
    logic                i_id_is_load;
    logic                i_id_is_md;

    logic                o_stall;
    logic [1:0]          o_fwd_a;
    logic [1:0]          o_fwd_b;
    logic                o_md_busy;
    logic                o_md_done;
    // W-slot write intent, for tracing which register retires this cycle
    logic                o_wb_we;
    logic [REG_BITS-1:0] o_wb_rd;

    modport master (
        output i_id_valid, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt,
               i_id_rd, i_id_writes, i_id_is_load, i_id_is_md,
        input  o_stall, o_fwd_a, o_fwd_b, o_md_busy, o_md_done, o_wb_we, o_wb_rd
    );

    modport slave (
        input  i_id_valid, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt,
               i_id_rd, i_id_writes, i_id_is_load, i_id_is_md,
        output o_stall, o_fwd_a, o_fwd_b, o_md_busy, o_md_done, o_wb_we, o_wb_rd
    );
endinterface

// File: rtl/hazard_bypass_unit.sv
// Decode-side hazard controller: tracks X/M/W destinations, registers X-stage
// bypass selects, and stalls on load-use and multiply/divide dependencies.
module hazard_bypass_unit #(
    parameter int REG_BITS   = 5,
    parameter int MD_LATENCY = 17
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    hazard_bypass_unit_if.slave  bus
);
    localparam int                CNT_BITS = $clog2(MD_LATENCY);
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(MD_LATENCY - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    // state    | meaning
    // MD_IDLE  | no multdiv in flight
    // MD_BUSY  | multdiv counting down; md_done on the cnt==0 cycle
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t r_md_state;
    md_state_t w_md_next;

    logic                r_x_valid, r_x_writes, r_x_load;
    logic [REG_BITS-1:0] r_x_rd;
    logic                r_m_valid, r_m_writes;
    logic [REG_BITS-1:0] r_m_rd;
    logic                r_w_valid, r_w_writes;
    logic [REG_BITS-1:0] r_w_rd;
    logic [1:0]          r_fwd_a, r_fwd_b;
    logic [CNT_BITS-1:0] r_md_cnt;
    logic [REG_BITS-1:0] r_md_rd;

    logic w_rs_live, w_rt_live, w_rd_live;
    logic w_rs_x, w_rt_x, w_rs_m, w_rt_m;
    logic w_load_use, w_md_hit, w_stall, w_issue;
    logic w_md_busy, w_md_done, w_md_start;
    logic [1:0] w_sel_a, w_sel_b;

    // Register 0 is hardwired zero, so it is excluded from every comparison.
    assign w_rs_live = bus.i_id_uses_rs & (bus.i_id_rs != '0);
    assign w_rt_live = bus.i_id_uses_rt & (bus.i_id_rt != '0);
    assign w_rd_live = bus.i_id_writes  & (bus.i_id_rd != '0);

    assign w_rs_x = w_rs_live & r_x_valid & r_x_writes & (r_x_rd == bus.i_id_rs);
    assign w_rt_x = w_rt_live & r_x_valid & r_x_writes & (r_x_rd == bus.i_id_rt);
    assign w_rs_m = w_rs_live & r_m_valid & r_m_writes & (r_m_rd == bus.i_id_rs);
    assign w_rt_m = w_rt_live & r_m_valid & r_m_writes & (r_m_rd == bus.i_id_rt);

    assign w_md_busy  = (r_md_state == MD_BUSY);
    assign w_load_use = bus.i_id_valid & r_x_load & (w_rs_x | w_rt_x);
    assign w_md_hit   = w_md_busy & bus.i_id_valid &
                        (bus.i_id_is_md |
                         (w_rs_live & (bus.i_id_rs == r_md_rd)) |
                         (w_rt_live & (bus.i_id_rt == r_md_rd)) |
                         (w_rd_live & (bus.i_id_rd == r_md_rd)));
    assign w_stall    = ~i_reset & (w_load_use | w_md_hit);
    assign w_issue    = bus.i_id_valid & ~w_stall;
    assign w_md_start = w_issue & bus.i_id_is_md;

    // A load still in X cannot forward; the stall covers that case instead.
    always_comb begin
        w_sel_a = 2'b00;
        w_sel_b = 2'b00;
        if (w_rs_x & ~r_x_load) begin
            w_sel_a = 2'b01;
        end else if (w_rs_m) begin
            w_sel_a = 2'b10;
        end
        if (w_rt_x & ~r_x_load) begin
            w_sel_b = 2'b01;
        end else if (w_rt_m) begin
            w_sel_b = 2'b10;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_x_valid  <= 1'b0;
            r_x_writes <= 1'b0;
            r_x_load   <= 1'b0;
            r_x_rd     <= '0;
            r_m_valid  <= 1'b0;
            r_m_writes <= 1'b0;
            r_m_rd     <= '0;
            r_w_valid  <= 1'b0;
            r_w_writes <= 1'b0;
            r_w_rd     <= '0;
            r_fwd_a    <= 2'b00;
            r_fwd_b    <= 2'b00;
        end else begin
            r_w_valid  <= r_m_valid;
            r_w_writes <= r_m_writes;
            r_w_rd     <= r_m_rd;
            r_m_valid  <= r_x_valid;
            r_m_writes <= r_x_writes;
            r_m_rd     <= r_x_rd;
            r_x_valid  <= w_issue;
            // Multdiv results return through md_done, never through the bypass network.
            r_x_writes <= w_issue & bus.i_id_writes & ~bus.i_id_is_md;
            r_x_load   <= w_issue & bus.i_id_is_load;
            r_x_rd     <= w_issue ? bus.i_id_rd : '0;
            r_fwd_a    <= w_issue ? w_sel_a : 2'b00;
            r_fwd_b    <= w_issue ? w_sel_b : 2'b00;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_md_state <= MD_IDLE;
        end else begin
            r_md_state <= w_md_next;
        end
    end

    always_comb begin
        w_md_next = r_md_state;
        w_md_done = 1'b0;
        case (r_md_state)
            MD_IDLE: begin
                if (w_md_start) begin
                    w_md_next = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (r_md_cnt == '0) begin
                    w_md_next = MD_IDLE;
                    w_md_done = ~i_reset;
                end
            end
            default: w_md_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_md_cnt <= '0;
            r_md_rd  <= '0;
        end else if (!w_md_busy && w_md_start) begin
            r_md_cnt <= CNT_INIT;
            r_md_rd  <= bus.i_id_rd;
        end else if (w_md_busy && (r_md_cnt != '0)) begin
            r_md_cnt <= r_md_cnt - CNT_ONE;
        end
    end

    assign bus.o_stall   = w_stall;
    assign bus.o_fwd_a   = r_fwd_a;
    assign bus.o_fwd_b   = r_fwd_b;
    assign bus.o_md_busy = w_md_busy;
    assign bus.o_md_done = w_md_done;
    assign bus.o_wb_we   = r_w_valid & r_w_writes;
    assign bus.o_wb_rd   = r_w_rd;
endmodule

// File: tb/tb_hazard_bypass_unit.sv
// Scenario bench for hazard_bypass_unit: expected bypass selects are queued when an
// instruction is presented and compared once the registered select appears.
module tb_hazard_bypass_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        string      nm;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    hazard_bypass_unit_if #(.REG_BITS(5)) bus ();

    hazard_bypass_unit #(.REG_BITS(5), .MD_LATENCY(17)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic md);
        bus.i_id_valid   = v;
        bus.i_id_rs      = rs;
        bus.i_id_rt      = rt;
        bus.i_id_uses_rs = urs;
        bus.i_id_uses_rt = urt;
        bus.i_id_rd      = rd;
        bus.i_id_writes  = wr;
        bus.i_id_is_load = ld;
        bus.i_id_is_md   = md;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic flush();
        nop();
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        drive(1, 3, 4, 1, 1, 5, 1, 0, 0);
        @(negedge clk);
        n_chk++;
        if (bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall_in_reset: stall=%b want 0", bus.o_stall); end
        n_chk++;
        if (bus.o_md_done !== 1'b0) begin n_fail++; $display("FAIL rst_done_in_reset: md_done=%b want 0", bus.o_md_done); end
        cyc();
        rst = 1'b0;
        n_chk++;
        if ({bus.o_fwd_a, bus.o_fwd_b, bus.o_md_busy, bus.o_md_done} !== 6'b000000) begin
            n_fail++;
            $display("FAIL rst_outputs: fwd_a=%b fwd_b=%b busy=%b done=%b want 00 00 0 0",
                     bus.o_fwd_a, bus.o_fwd_b, bus.o_md_busy, bus.o_md_done);
        end
        @(negedge clk);
        n_chk++;
        if (bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall_after: stall=%b want 0", bus.o_stall); end
        flush();
    endtask

    task automatic test_back_to_back();
        flush();
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0);
        sbq.push_back('{2'b00, 2'b00, "b2b_add_r3"});
        cyc();
        e = sbq.pop_front();
        n_chk++;
        if ({bus.o_fwd_a, bus.o_fwd_b} !== {e.a, e.b}) begin n_fail++; $display("FAIL %s: fwd=%b/%b want %b/%b", e.nm, bus.o_fwd_a, bus.o_fwd_b, e.a, e.b); end
        drive(1, 3, 3, 1, 1, 4, 1, 0, 0);
        @(negedge clk);
        n_chk++;
        if (bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: stall=%b want 0", bus.o_stall); end
        sbq.push_back('{2'b01, 2'b01, "b2b_add_r4"});
        cyc();
        e = sbq.pop_front();
        n_chk++;
        if ({bus.o_fwd_a, bus.o_fwd_b} !== {e.a, e.b}) begin n_fail++; $display("FAIL %s: fwd=%b/%b want %b/%b", e.nm, bus.o_fwd_a, bus.o_fwd_b, e.a, e.b); end
        nop();
        cyc();
        n_chk++;
        if ({bus.o_wb_we, bus.o_wb_rd} !== {1'b1, 5'd3}) begin n_fail++; $display("FAIL b2b_wb_r3: we=%b rd=%0d want 1 3", bus.o_wb_we, bus.o_wb_rd); end
        cyc();
        n_chk++;
        if ({bus.o_wb_we, bus.o_wb_rd} !== {1'b1, 5'd4}) begin n_fail++; $display("FAIL b2b_wb_r4: we=%b rd=%0d want 1 4", bus.o_wb_we, bus.o_wb_rd); end
    endtask

    task automatic test_m_forward();
        flush();
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0);
        cyc();
        nop();
        cyc();
        drive(1, 3, 1, 1, 1, 5, 1, 0, 0);
        sbq.push_back('{2'b10, 2'b00, "mfwd_sub_r5"});
        cyc();
        e = sbq.pop_front();
        n_chk++;
        if ({bus.o_fwd_a, bus.o_fwd_b} !== {e.a, e.b}) begin n_fail++; $display("FAIL %s: fwd=%b/%b want %b/%b", e.nm, bus.o_fwd_a, bus.o_fwd_b, e.a, e.b); end
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0);
        cyc();
        cyc();
        // r3 now in both X and M, r5 only in W: X must win, W must not forward
        drive(1, 3, 5, 1, 1, 6, 1, 0, 0);
        sbq.push_back('{2'b01, 2'b00, "mfwd_x_over_m"});
        cyc();
        e = sbq.pop_front();
        n_chk++;
        if ({bus.o_fwd_a, bus.o_fwd_b} !== {e.a, e.b}) begin n_fail++; $display("FAIL %s: fwd=%b/%b want %b/%b", e.nm, bus.o_fwd_a, bus.o_fwd_b, e.a, e.b); end
        nop();
    endtask

    task automatic test_load_use();
        for (int side = 0; side < 2; side++) begin
            flush();
            drive(1, 2, 0, 1, 0, 7, 1, 1, 0);
            cyc();
            if (side == 0) drive(1, 7, 2, 1, 1, 8, 1, 0, 0);
            else           drive(1, 2, 7, 1, 1, 8, 1, 0, 0);
            @(negedge clk);
            n_chk++;
            if (bus.o_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall_%0d: stall=%b want 1", side, bus.o_stall); end
            sbq.push_back('{2'b00, 2'b00, "lu_bubble"});
            cyc();
            e = sbq.pop_front();
            n_chk++;
            if ({bus.o_fwd_a, bus.o_fwd_b} !== {e.a, e.b}) begin n_fail++; $display("FAIL %s: fwd=%b/%b want %b/%b", e.nm, bus.o_fwd_a, bus.o_fwd_b, e.a, e.b); end
            @(negedge clk);
            n_chk++;
            if (bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL lu_release_%0d: stall=%b want 0", side, bus.o_stall); end
            if (side == 0) sbq.push_back('{2'b10, 2'b00, "lu_issue_rs"});
            else           sbq.push_back('{2'b00, 2'b10, "lu_issue_rt"});
            cyc();
            e = sbq.pop_front();
            n_chk++;
            if ({bus.o_fwd_a, bus.o_fwd_b} !== {e.a, e.b}) begin n_fail++; $display("FAIL %s: fwd=%b/%b want %b/%b", e.nm, bus.o_fwd_a, bus.o_fwd_b, e.a, e.b); end
        end
        nop();
    endtask

    task automatic test_reg_zero();
        int waited;
        flush();
        for (int kind = 0; kind < 3; kind++) begin
            drive(1, 1, 2, 1, 1, 0, 1, kind == 1, kind == 2);
            cyc();
            drive(1, 0, 0, 1, 1, 6, 1, 0, 0);
            @(negedge clk);
            n_chk++;
            if (bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall_%0d: stall=%b want 0", kind, bus.o_stall); end
            sbq.push_back('{2'b00, 2'b00, "r0_fwd"});
            cyc();
            e = sbq.pop_front();
            n_chk++;
            if ({bus.o_fwd_a, bus.o_fwd_b} !== {e.a, e.b}) begin n_fail++; $display("FAIL %s(%0d): fwd=%b/%b want %b/%b", e.nm, kind, bus.o_fwd_a, bus.o_fwd_b, e.a, e.b); end
        end
        nop();
        waited = 0;
        while (bus.o_md_busy === 1'b1 && waited < 40) begin cyc(); waited++; end
        n_chk++;
        if (bus.o_md_busy !== 1'b0) begin n_fail++; $display("FAIL r0_md_drain: busy=%b want 0 after %0d cycles", bus.o_md_busy, waited); end
    endtask

    task automatic test_multdiv();
        int stalls, dones;
        logic issued;
        flush();
        // mul r9 then dependent add r10,r9,r1
        drive(1, 1, 2, 1, 1, 9, 1, 0, 1);
        cyc();
        n_chk++;
        if (bus.o_md_busy !== 1'b1) begin n_fail++; $display("FAIL md_busy_set: busy=%b want 1", bus.o_md_busy); end
        drive(1, 9, 1, 1, 1, 10, 1, 0, 0);
        stalls = 0; dones = 0; issued = 1'b0;
        for (int k = 0; k < 40 && !issued; k++) begin
            @(negedge clk);
            if (bus.o_md_done === 1'b1) dones++;
            if (bus.o_stall === 1'b1) stalls++; else issued = 1'b1;
            cyc();
        end
        n_chk++;
        if (!issued || stalls != 17) begin n_fail++; $display("FAIL md_raw_stall: stalls=%0d issued=%b want 17 1", stalls, issued); end
        n_chk++;
        if (dones != 1) begin n_fail++; $display("FAIL md_done_once: pulses=%0d want 1", dones); end
        n_chk++;
        if ({bus.o_md_busy, bus.o_fwd_a, bus.o_fwd_b} !== 5'b00000) begin n_fail++; $display("FAIL md_after: busy=%b fwd=%b/%b want 0 00/00", bus.o_md_busy, bus.o_fwd_a, bus.o_fwd_b); end

        // mul r9, unrelated add, then second mul r11 waits out the window
        drive(1, 1, 2, 1, 1, 9, 1, 0, 1);
        cyc();
        drive(1, 12, 13, 1, 1, 14, 1, 0, 0);
        @(negedge clk);
        n_chk++;
        if (bus.o_stall !== 1'b0) begin n_fail++; $display("FAIL md_indep: stall=%b want 0", bus.o_stall); end
        cyc();
        drive(1, 4, 5, 1, 1, 11, 1, 0, 1);
        stalls = 0; dones = 0; issued = 1'b0;
        for (int k = 0; k < 40 && !issued; k++) begin
            @(negedge clk);
            if (bus.o_md_done === 1'b1) dones++;
            if (bus.o_stall === 1'b1) stalls++; else issued = 1'b1;
            cyc();
        end
        n_chk++;
        if (!issued || stalls != 16 || dones != 1) begin n_fail++; $display("FAIL md_second_mul: stalls=%0d done=%0d issued=%b want 16 1 1", stalls, dones, issued); end

        // write-after-write on the multdiv destination r11
        drive(1, 0, 0, 0, 0, 11, 1, 0, 0);
        stalls = 0; dones = 0; issued = 1'b0;
        for (int k = 0; k < 40 && !issued; k++) begin
            @(negedge clk);
            if (bus.o_md_done === 1'b1) dones++;
            if (bus.o_stall === 1'b1) stalls++; else issued = 1'b1;
            cyc();
        end
        n_chk++;
        if (!issued || stalls != 17 || dones != 1) begin n_fail++; $display("FAIL md_waw: stalls=%0d done=%0d issued=%b want 17 1 1", stalls, dones, issued); end
        nop();
    endtask

    task automatic test_reset_mid_md();
        int dones;
        flush();
        drive(1, 1, 2, 1, 1, 9, 1, 0, 1);
        cyc();
        drive(1, 9, 1, 1, 1, 10, 1, 0, 0);
        repeat (4) cyc();
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({bus.o_stall, bus.o_md_done} !== 2'b00) begin n_fail++; $display("FAIL rmd_in_reset: stall=%b done=%b want 0 0", bus.o_stall, bus.o_md_done); end
        sbq.push_back('{2'b00, 2'b00, "rmd_fwd"});
        cyc();
        rst = 1'b0;
        e = sbq.pop_front();
        n_chk++;
        if ({bus.o_fwd_a, bus.o_fwd_b} !== {e.a, e.b}) begin n_fail++; $display("FAIL %s: fwd=%b/%b want %b/%b", e.nm, bus.o_fwd_a, bus.o_fwd_b, e.a, e.b); end
        @(negedge clk);
        n_chk++;
        if ({bus.o_md_busy, bus.o_md_done, bus.o_stall} !== 3'b000) begin n_fail++; $display("FAIL rmd_after: busy=%b done=%b stall=%b want 0 0 0", bus.o_md_busy, bus.o_md_done, bus.o_stall); end
        cyc();
        nop();
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.o_md_done === 1'b1) dones++;
            cyc();
        end
        n_chk++;
        if (dones != 0) begin n_fail++; $display("FAIL rmd_no_done: pulses=%0d want 0", dones); end
    endtask

    initial begin
        nop();
        cyc();
        test_reset();
        test_back_to_back();
        test_m_forward();
        test_load_use();
        test_reg_zero();
        test_multdiv();
        test_reset_mid_md();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
